// File: rtl/ann_pkg.sv
// ann_pkg: shared definitions for the ANN coefficient loader.
//   WORD_W          - width of one memory / array word
//   loader_state_t  - loader FSM state encoding
//   coef_set_words  - number of words in one coefficient set (rows * columns)
package ann_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        IMG_REQ   = 3'd1,
        IMG_WAIT  = 3'd2,
        COEF_REQ  = 3'd3,
        COEF_WAIT = 3'd4,
        DONE      = 3'd5
    } loader_state_t;

    // Words in one coefficient set: one IMAGE_SIZE-word row per first-layer neuron.
    function automatic int unsigned coef_set_words(input int unsigned rows,
                                                   input int unsigned cols);
        return rows * cols;
    endfunction

endpackage

// File: rtl/loader_addr_gen.sv
// loader_addr_gen: read-address counter plus row/column word counters for
// the coefficient loader.
//   clk, n_rst  - clock, synchronous active-low reset
//   start_img   - load the image base address, clear counters, image mode
//   start_coef  - load the coefficient base of set_sel, clear counters, coef mode
//   set_sel     - coefficient set index used with start_coef
//   step        - one word captured: advance address and column/row
//   addr        - current read address (register)
//   row, col    - weight row / column (col doubles as the image index)
//   last        - current word is the final one of the running fetch
module loader_addr_gen
    import ann_pkg::*;
#(
    parameter int FIRST_LAYER = 16,
    parameter int IMAGE_SIZE  = 64,
    parameter int ADDR_W      = 16,
    parameter int IMAGE_BASE  = 0,
    parameter int COEF_BASE   = 64,
    parameter int ROW_W       = 4,
    parameter int COL_W       = 6
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start_img,
    input  logic              start_coef,
    input  logic              set_sel,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic [ROW_W-1:0]  row,
    output logic [COL_W-1:0]  col,
    output logic              last
);

    localparam int unsigned     SET_WORDS = coef_set_words(FIRST_LAYER, IMAGE_SIZE);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_SIZE - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FIRST_LAYER - 1);

    logic                coef_mode_r;
    logic [ADDR_W-1:0]   set_base_s;

    // Base address of the selected coefficient set.
    always_comb begin
        if (set_sel) begin
            set_base_s = ADDR_W'(COEF_BASE) + ADDR_W'(SET_WORDS);
        end else begin
            set_base_s = ADDR_W'(COEF_BASE);
        end
    end

    // Address and row/column counters; a start always overrides a step so the
    // image-to-coefficient handover reloads rather than increments.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            addr        <= {ADDR_W{1'b0}};
            row         <= {ROW_W{1'b0}};
            col         <= {COL_W{1'b0}};
            coef_mode_r <= 1'b0;
        end else if (start_img) begin
            addr        <= ADDR_W'(IMAGE_BASE);
            row         <= {ROW_W{1'b0}};
            col         <= {COL_W{1'b0}};
            coef_mode_r <= 1'b0;
        end else if (start_coef) begin
            addr        <= set_base_s;
            row         <= {ROW_W{1'b0}};
            col         <= {COL_W{1'b0}};
            coef_mode_r <= 1'b1;
        end else if (step) begin
            addr <= addr + ADDR_W'(1);
            if (col == COL_LAST) begin
                col <= {COL_W{1'b0}};
                row <= row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end else begin
            addr <= addr;
        end
    end

    // Last-word flag: image ends at the final column, a coefficient set at the
    // final column of the final row.
    always_comb begin
        if (coef_mode_r) begin
            last = (row == ROW_LAST) && (col == COL_LAST);
        end else begin
            last = (col == COL_LAST);
        end
    end

endmodule

// File: rtl/ann_coef_loader.sv
// ann_coef_loader: fetches the image and first-layer coefficient sets from a
// single-port read memory into registered arrays for the ANN core.
//   clk, n_rst            - clock, synchronous active-low reset
//   load_start            - pulse: load image then coefficient set 0
//   request_coef          - rising edge requests coefficient set coef_select
//   coef_select           - set index, sampled on the request_coef edge
//   mem_ren, mem_addr     - one-cycle read strobe and its address
//   mem_rdata, mem_rvalid - read data and its valid strobe
//   image, weights        - registered image words and weight array
//   image_weights_loaded  - pulse at the end of a load_start sequence
//   coef_loaded           - pulse at the end of a request_coef reload
//   busy                  - high whenever the loader is not idle
module ann_coef_loader
    import ann_pkg::*;
#(
    parameter int FIRST_LAYER = 16,
    parameter int IMAGE_SIZE  = 64,
    parameter int ADDR_W      = 16,
    parameter int IMAGE_BASE  = 0,
    parameter int COEF_BASE   = 64
) (
    input  logic                                           clk,
    input  logic                                           n_rst,
    input  logic                                           load_start,
    input  logic                                           request_coef,
    input  logic                                           coef_select,
    output logic                                           mem_ren,
    output logic [ADDR_W-1:0]                              mem_addr,
    input  logic [WORD_W-1:0]                              mem_rdata,
    input  logic                                           mem_rvalid,
    output logic [IMAGE_SIZE-1:0][WORD_W-1:0]              image,
    output logic [FIRST_LAYER-1:0][IMAGE_SIZE-1:0][WORD_W-1:0] weights,
    output logic                                           image_weights_loaded,
    output logic                                           coef_loaded,
    output logic                                           busy
);

    localparam int ROW_W = (FIRST_LAYER > 1) ? $clog2(FIRST_LAYER) : 1;
    localparam int COL_W = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;

    loader_state_t    state_r;
    loader_state_t    next_state_s;
    logic             req_q_r;
    logic             req_edge_s;
    logic             full_load_r;
    logic             start_img_s;
    logic             start_coef_s;
    logic             set_sel_s;
    logic             step_s;
    logic             img_cap_s;
    logic             coef_cap_s;
    logic [ROW_W-1:0] row_s;
    logic [COL_W-1:0] col_s;
    logic             last_s;

    assign req_edge_s = request_coef & ~req_q_r;
    assign img_cap_s  = (state_r == IMG_WAIT) && mem_rvalid;
    assign coef_cap_s = (state_r == COEF_WAIT) && mem_rvalid;

    loader_addr_gen #(
        .FIRST_LAYER (FIRST_LAYER),
        .IMAGE_SIZE  (IMAGE_SIZE),
        .ADDR_W      (ADDR_W),
        .IMAGE_BASE  (IMAGE_BASE),
        .COEF_BASE   (COEF_BASE),
        .ROW_W       (ROW_W),
        .COL_W       (COL_W)
    ) u_addr_gen (
        .clk        (clk),
        .n_rst      (n_rst),
        .start_img  (start_img_s),
        .start_coef (start_coef_s),
        .set_sel    (set_sel_s),
        .step       (step_s),
        .addr       (mem_addr),
        .row        (row_s),
        .col        (col_s),
        .last       (last_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic and counter controls. load_start has priority over a
    // request edge arriving in the same idle cycle; the edge is then lost.
    always_comb begin
        next_state_s = state_r;
        start_img_s  = 1'b0;
        start_coef_s = 1'b0;
        set_sel_s    = 1'b0;
        step_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (load_start) begin
                    next_state_s = IMG_REQ;
                    start_img_s  = 1'b1;
                end else if (req_edge_s) begin
                    next_state_s = COEF_REQ;
                    start_coef_s = 1'b1;
                    set_sel_s    = coef_select;
                end else begin
                    next_state_s = IDLE;
                end
            end
            IMG_REQ: begin
                next_state_s = IMG_WAIT;
            end
            IMG_WAIT: begin
                if (mem_rvalid) begin
                    if (last_s) begin
                        // Image complete: chain straight into coefficient set 0.
                        next_state_s = COEF_REQ;
                        start_coef_s = 1'b1;
                    end else begin
                        next_state_s = IMG_REQ;
                        step_s       = 1'b1;
                    end
                end else begin
                    next_state_s = IMG_WAIT;
                end
            end
            COEF_REQ: begin
                next_state_s = COEF_WAIT;
            end
            COEF_WAIT: begin
                if (mem_rvalid) begin
                    step_s = 1'b1;
                    if (last_s) begin
                        next_state_s = DONE;
                    end else begin
                        next_state_s = COEF_REQ;
                    end
                end else begin
                    next_state_s = COEF_WAIT;
                end
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Edge-detect copy of request_coef and the full-load flag that selects
    // which completion pulse fires.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            req_q_r     <= 1'b0;
            full_load_r <= 1'b0;
        end else begin
            req_q_r <= request_coef;
            if (start_img_s) begin
                full_load_r <= 1'b1;
            end else if (start_coef_s && (state_r == IDLE)) begin
                full_load_r <= 1'b0;
            end else begin
                full_load_r <= full_load_r;
            end
        end
    end

    // Registered control outputs, decoded from the state being entered so they
    // line up with that state's cycle.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            mem_ren              <= 1'b0;
            busy                 <= 1'b0;
            image_weights_loaded <= 1'b0;
            coef_loaded          <= 1'b0;
        end else begin
            mem_ren              <= (next_state_s == IMG_REQ) || (next_state_s == COEF_REQ);
            busy                 <= (next_state_s != IDLE);
            image_weights_loaded <= (next_state_s == DONE) && full_load_r;
            coef_loaded          <= (next_state_s == DONE) && !full_load_r;
        end
    end

    // Array capture: only the word addressed by the column/row counters changes.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            image   <= '0;
            weights <= '0;
        end else if (img_cap_s) begin
            image[col_s] <= mem_rdata;
        end else if (coef_cap_s) begin
            weights[row_s][col_s] <= mem_rdata;
        end else begin
            image <= image;
        end
    end

endmodule

// File: tb/tb_ann_coef_loader.sv
module tb_ann_coef_loader;

    localparam int FL   = 16;
    localparam int IS   = 64;
    localparam int AW   = 16;
    localparam int IB   = 0;
    localparam int CB   = 64;
    localparam int SETW = FL * IS;

    logic                      clk = 1'b0;
    logic                      n_rst;
    logic                      load_start;
    logic                      request_coef;
    logic                      coef_select;
    logic                      mem_ren;
    logic [AW-1:0]             mem_addr;
    logic [15:0]               mem_rdata;
    logic                      mem_rvalid;
    logic [IS-1:0][15:0]       image;
    logic [FL-1:0][IS-1:0][15:0] weights;
    logic                      image_weights_loaded;
    logic                      coef_loaded;
    logic                      busy;

    int tests_run    = 0;
    int tests_failed = 0;

    // memory responder / scoreboard state
    logic [AW-1:0] exp_addr_q[$];
    bit            pend     = 1'b0;
    int            wait_cnt = 0;
    logic [AW-1:0] pend_addr;
    bit            var_lat  = 1'b0;
    bit            spur_en  = 1'b0;
    int            ren_cnt  = 0;
    int            addr_err = 0;

    // monitors
    int cyc     = 0;
    int iwl_cnt = 0;
    int iwl_cyc = 0;
    int cl_cnt  = 0;

    // expected array model
    logic [15:0] exp_image[IS];
    logic [15:0] exp_w[FL][IS];

    ann_coef_loader #(
        .FIRST_LAYER (FL),
        .IMAGE_SIZE  (IS),
        .ADDR_W      (AW),
        .IMAGE_BASE  (IB),
        .COEF_BASE   (CB)
    ) dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .load_start           (load_start),
        .request_coef         (request_coef),
        .coef_select          (coef_select),
        .mem_ren              (mem_ren),
        .mem_addr             (mem_addr),
        .mem_rdata            (mem_rdata),
        .mem_rvalid           (mem_rvalid),
        .image                (image),
        .weights              (weights),
        .image_weights_loaded (image_weights_loaded),
        .coef_loaded          (coef_loaded),
        .busy                 (busy)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory: data at address a is a ^ A5A5, returned 1 (+ optional 0..5) cycles
    // after the strobe; each strobe is checked against the expected-address queue.
    initial begin
        logic [AW-1:0] exp_a;
        mem_rvalid = 1'b0;
        mem_rdata  = 16'h0000;
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (pend) begin
                if (wait_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = pend_addr ^ 16'hA5A5;
                    pend       = 1'b0;
                end else begin
                    wait_cnt--;
                end
            end
            if (mem_ren === 1'b1) begin
                ren_cnt++;
                if (pend) addr_err++;
                if (exp_addr_q.size() == 0) begin
                    addr_err++;
                end else begin
                    exp_a = exp_addr_q.pop_front();
                    if (mem_addr !== exp_a) addr_err++;
                end
                pend      = 1'b1;
                pend_addr = mem_addr;
                wait_cnt  = var_lat ? int'($urandom_range(0, 5)) : 0;
                if (spur_en && ($urandom_range(0, 2) == 0)) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = 16'hDEAD;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (image_weights_loaded === 1'b1) begin
            iwl_cnt++;
            iwl_cyc = cyc;
        end
        if (coef_loaded === 1'b1) cl_cnt++;
    end

    task automatic push_image_fetch();
        for (int i = 0; i < IS; i++) begin
            exp_addr_q.push_back(AW'(IB + i));
            exp_image[i] = 16'(IB + i) ^ 16'hA5A5;
        end
    endtask

    task automatic push_coef_fetch(input int set);
        for (int k = 0; k < SETW; k++) begin
            exp_addr_q.push_back(AW'(CB + set * SETW + k));
            exp_w[k / IS][k % IS] = 16'(CB + set * SETW + k) ^ 16'hA5A5;
        end
    endtask

    task automatic wait_idle(input int budget, output bit timed_out);
        int n = 0;
        while ((busy === 1'b1) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        timed_out = (busy === 1'b1);
    endtask

    task automatic test_reset();
        int bad = 0;
        n_rst = 1'b0; load_start = 1'b0; request_coef = 1'b0; coef_select = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({busy, mem_ren, image_weights_loaded, coef_loaded} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_ctrl: busy/ren/iwl/cl=%b required 0000", {busy, mem_ren, image_weights_loaded, coef_loaded});
        end
        tests_run++;
        if (mem_addr !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_addr: got %0h required 0", mem_addr);
        end
        for (int i = 0; i < IS; i++) if (image[i] !== 16'h0000) bad++;
        for (int r = 0; r < FL; r++) for (int c = 0; c < IS; c++) if (weights[r][c] !== 16'h0000) bad++;
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL reset_arrays: %0d nonzero words, required 0", bad);
        end
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release_busy: got %b required 0", busy);
        end
    endtask

    task automatic test_full_load();
        int ren0, iwl0, cl0, accept, bad;
        bit to;
        addr_err = 0; bad = 0;
        push_image_fetch();
        push_coef_fetch(0);
        ren0 = ren_cnt; iwl0 = iwl_cnt; cl0 = cl_cnt;
        @(negedge clk);
        load_start = 1'b1;
        accept = cyc + 1;
        @(negedge clk);
        load_start = 1'b0;
        tests_run++;
        if ({busy, mem_ren} !== 2'b11 || mem_addr !== AW'(IB)) begin
            tests_failed++;
            $display("FAIL full_first_req: busy/ren=%b addr=%0d required 11 addr=%0d", {busy, mem_ren}, mem_addr, IB);
        end
        wait_idle(3000, to);
        @(negedge clk);
        tests_run++;
        if (to) begin
            tests_failed++;
            $display("FAIL full_timeout: busy still %b after budget, required 0", busy);
        end
        tests_run++;
        if (iwl_cnt - iwl0 !== 1) begin
            tests_failed++;
            $display("FAIL full_iwl_count: got %0d required 1", iwl_cnt - iwl0);
        end
        tests_run++;
        if (iwl_cyc - accept !== 2 * IS + 2 * SETW) begin
            tests_failed++;
            $display("FAIL full_latency: got %0d required %0d", iwl_cyc - accept, 2 * IS + 2 * SETW);
        end
        tests_run++;
        if (cl_cnt !== cl0) begin
            tests_failed++;
            $display("FAIL full_cl_quiet: got %0d pulses required 0", cl_cnt - cl0);
        end
        tests_run++;
        if (ren_cnt - ren0 !== IS + SETW || addr_err !== 0 || exp_addr_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL full_reads: ren=%0d adr_err=%0d left=%0d required %0d/0/0", ren_cnt - ren0, addr_err, exp_addr_q.size(), IS + SETW);
        end
        tests_run++;
        if (image[5] !== (16'd5 ^ 16'hA5A5)) begin
            tests_failed++;
            $display("FAIL full_image5: got %0h required %0h", image[5], 16'd5 ^ 16'hA5A5);
        end
        tests_run++;
        if (weights[3][7] !== (16'd263 ^ 16'hA5A5)) begin
            tests_failed++;
            $display("FAIL full_w3_7: got %0h required %0h", weights[3][7], 16'd263 ^ 16'hA5A5);
        end
        for (int i = 0; i < IS; i++) if (image[i] !== exp_image[i]) bad++;
        for (int r = 0; r < FL; r++) for (int c = 0; c < IS; c++) if (weights[r][c] !== exp_w[r][c]) bad++;
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL full_arrays: %0d wrong words, required 0", bad);
        end
    endtask

    task automatic test_reload();
        int ren0, iwl0, cl0, bad_i, bad_w;
        bit to;
        addr_err = 0; bad_i = 0; bad_w = 0;
        push_coef_fetch(1);
        ren0 = ren_cnt; iwl0 = iwl_cnt; cl0 = cl_cnt;
        @(negedge clk);
        request_coef = 1'b1;
        coef_select  = 1'b1;
        @(negedge clk);
        coef_select = 1'b0;
        tests_run++;
        if (mem_ren !== 1'b1 || mem_addr !== AW'(CB + SETW)) begin
            tests_failed++;
            $display("FAIL reload_first_addr: ren=%b addr=%0d required 1 addr=%0d", mem_ren, mem_addr, CB + SETW);
        end
        wait_idle(3000, to);
        repeat (20) @(negedge clk);
        tests_run++;
        if (to || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reload_idle: timeout=%b busy=%b required 0 0", to, busy);
        end
        tests_run++;
        if (cl_cnt - cl0 !== 1 || iwl_cnt !== iwl0) begin
            tests_failed++;
            $display("FAIL reload_pulses: cl=%0d iwl=%0d required 1 0", cl_cnt - cl0, iwl_cnt - iwl0);
        end
        tests_run++;
        if (ren_cnt - ren0 !== SETW || addr_err !== 0 || exp_addr_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL reload_reads: ren=%0d adr_err=%0d left=%0d required %0d/0/0", ren_cnt - ren0, addr_err, exp_addr_q.size(), SETW);
        end
        tests_run++;
        if (weights[0][0] !== (16'd1088 ^ 16'hA5A5)) begin
            tests_failed++;
            $display("FAIL reload_w0_0: got %0h required %0h", weights[0][0], 16'd1088 ^ 16'hA5A5);
        end
        for (int i = 0; i < IS; i++) if (image[i] !== exp_image[i]) bad_i++;
        for (int r = 0; r < FL; r++) for (int c = 0; c < IS; c++) if (weights[r][c] !== exp_w[r][c]) bad_w++;
        tests_run++;
        if (bad_i !== 0 || bad_w !== 0) begin
            tests_failed++;
            $display("FAIL reload_arrays: image wrong=%0d weights wrong=%0d required 0 0", bad_i, bad_w);
        end
        request_coef = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n, iwl0, cl0, bad;
        n = 0; bad = 0;
        push_image_fetch();
        push_coef_fetch(0);
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        while (!(mem_ren === 1'b1 && mem_addr === AW'(CB + 300)) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (n >= 3000) begin
            tests_failed++;
            $display("FAIL rstmid_reach: word k=300 not requested within budget, addr=%0d", mem_addr);
        end
        iwl0 = iwl_cnt; cl0 = cl_cnt;
        n_rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({busy, mem_ren, image_weights_loaded, coef_loaded} !== 4'b0000 || mem_addr !== 16'h0000) begin
            tests_failed++;
            $display("FAIL rstmid_outputs: busy/ren/iwl/cl=%b addr=%0d required 0000 0", {busy, mem_ren, image_weights_loaded, coef_loaded}, mem_addr);
        end
        for (int i = 0; i < IS; i++) if (image[i] !== 16'h0000) bad++;
        for (int r = 0; r < FL; r++) for (int c = 0; c < IS; c++) if (weights[r][c] !== 16'h0000) bad++;
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL rstmid_arrays: %0d nonzero words, required 0", bad);
        end
        n_rst = 1'b1;
        exp_addr_q.delete();
        pend = 1'b0;
        repeat (10) @(negedge clk);
        tests_run++;
        if (iwl_cnt !== iwl0 || cl_cnt !== cl0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_no_pulse: iwl=%0d cl=%0d busy=%b required 0 0 0", iwl_cnt - iwl0, cl_cnt - cl0, busy);
        end
    endtask

    task automatic test_var_latency();
        int ren0, iwl0, cl0, bad;
        bit to;
        addr_err = 0; bad = 0;
        var_lat = 1'b1; spur_en = 1'b1;
        push_image_fetch();
        push_coef_fetch(0);
        ren0 = ren_cnt; iwl0 = iwl_cnt; cl0 = cl_cnt;
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        wait_idle(20000, to);
        @(negedge clk);
        var_lat = 1'b0; spur_en = 1'b0;
        tests_run++;
        if (to) begin
            tests_failed++;
            $display("FAIL varlat_timeout: busy still %b after budget, required 0", busy);
        end
        tests_run++;
        if (iwl_cnt - iwl0 !== 1 || cl_cnt !== cl0) begin
            tests_failed++;
            $display("FAIL varlat_pulses: iwl=%0d cl=%0d required 1 0", iwl_cnt - iwl0, cl_cnt - cl0);
        end
        tests_run++;
        if (ren_cnt - ren0 !== IS + SETW || addr_err !== 0 || exp_addr_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL varlat_reads: ren=%0d adr_err=%0d left=%0d required %0d/0/0", ren_cnt - ren0, addr_err, exp_addr_q.size(), IS + SETW);
        end
        for (int i = 0; i < IS; i++) if (image[i] !== exp_image[i]) bad++;
        for (int r = 0; r < FL; r++) for (int c = 0; c < IS; c++) if (weights[r][c] !== exp_w[r][c]) bad++;
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL varlat_arrays: %0d wrong words, required 0", bad);
        end
    endtask

    task automatic test_simultaneous();
        int ren0, iwl0, cl0;
        bit to;
        addr_err = 0;
        push_image_fetch();
        push_coef_fetch(0);
        ren0 = ren_cnt; iwl0 = iwl_cnt; cl0 = cl_cnt;
        @(negedge clk);
        load_start   = 1'b1;
        request_coef = 1'b1;
        coef_select  = 1'b1;
        @(negedge clk);
        load_start  = 1'b0;
        coef_select = 1'b0;
        tests_run++;
        if (mem_ren !== 1'b1 || mem_addr !== AW'(IB)) begin
            tests_failed++;
            $display("FAIL simul_first_addr: ren=%b addr=%0d required 1 addr=%0d", mem_ren, mem_addr, IB);
        end
        wait_idle(3000, to);
        repeat (5) @(negedge clk);
        tests_run++;
        if (to || iwl_cnt - iwl0 !== 1 || cl_cnt !== cl0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL simul_pulses: timeout=%b iwl=%0d cl=%0d busy=%b required 0 1 0 0", to, iwl_cnt - iwl0, cl_cnt - cl0, busy);
        end
        tests_run++;
        if (ren_cnt - ren0 !== IS + SETW || addr_err !== 0 || exp_addr_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL simul_reads: ren=%0d adr_err=%0d left=%0d required %0d/0/0", ren_cnt - ren0, addr_err, exp_addr_q.size(), IS + SETW);
        end
        request_coef = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_busy_ignore();
        int ren0, iwl0, cl0, bad;
        bit to;
        addr_err = 0; bad = 0;
        push_coef_fetch(0);
        ren0 = ren_cnt; iwl0 = iwl_cnt; cl0 = cl_cnt;
        @(negedge clk);
        request_coef = 1'b1;
        coef_select  = 1'b0;
        @(negedge clk);
        request_coef = 1'b0;
        repeat (100) @(negedge clk);
        load_start   = 1'b1;
        request_coef = 1'b1;
        coef_select  = 1'b1;
        @(negedge clk);
        load_start  = 1'b0;
        coef_select = 1'b0;
        repeat (50) @(negedge clk);
        request_coef = 1'b0;
        wait_idle(3000, to);
        repeat (5) @(negedge clk);
        tests_run++;
        if (to || cl_cnt - cl0 !== 1 || iwl_cnt !== iwl0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_pulses: timeout=%b cl=%0d iwl=%0d busy=%b required 0 1 0 0", to, cl_cnt - cl0, iwl_cnt - iwl0, busy);
        end
        tests_run++;
        if (ren_cnt - ren0 !== SETW || addr_err !== 0 || exp_addr_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL busy_reads: ren=%0d adr_err=%0d left=%0d required %0d/0/0", ren_cnt - ren0, addr_err, exp_addr_q.size(), SETW);
        end
        for (int i = 0; i < IS; i++) if (image[i] !== exp_image[i]) bad++;
        for (int r = 0; r < FL; r++) for (int c = 0; c < IS; c++) if (weights[r][c] !== exp_w[r][c]) bad++;
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL busy_arrays: %0d wrong words, required 0", bad);
        end
    endtask

    initial begin
        n_rst        = 1'b0;
        load_start   = 1'b0;
        request_coef = 1'b0;
        coef_select  = 1'b0;
        test_reset();
        test_full_load();
        test_reload();
        test_reset_mid();
        test_var_latency();
        test_simultaneous();
        test_busy_ignore();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
